// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART controller slice.
// Contents:
//   DEFAULT_CLK_HZ / DEFAULT_BAUD : default clock and bit rate
//   BYTE_W                        : width of every byte stream in the slice
//   tx_state_e                    : encoding of the transmit sequencer state
package uart_ctrl_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;
    localparam int unsigned DEFAULT_BAUD   = 9600;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_BUSY  = 2'd2,
        TX_DONE  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_ctrl_fifo.sv
// byte_fifo: registered first-word-fall-through byte FIFO.
// Ports:
//   clk, reset         : clock, synchronous active-low reset (pointers only)
//   push, din          : write request and data; ignored while full
//   pop                : read request; ignored while empty
//   dout               : current head, valid while empty=0
//   full, empty        : status from pointers with one extra wrap bit
// A push into an empty FIFO shows on dout the following cycle. On a full
// FIFO a same-cycle push is refused even if a pop happens, because full is
// taken from the registered pointers.
module byte_fifo
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        // Same slot but different lap: writer is a whole buffer ahead.
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: wraps a byte-level UART core with FIFO-buffered byte streams.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   tx_valid/tx_data/tx_ready : outgoing byte stream from the core
//   rx_valid/rx_data/rx_ready : incoming byte stream to the core
//   rx_overflow           : sticky, a received byte was dropped (RX FIFO full)
//   tx_idle               : nothing queued and no frame in flight
//   uart_enable           : one-cycle baud tick to the UART core
//   uart_data_tx          : transmit hold register, stable for a whole frame
//   uart_start_transmit   : start request, held until the core accepts
//   uart_tx_ready         : UART core not transmitting
//   uart_data_rx, uart_receive_done : last received byte and its done level
// Stream handshake: a byte moves on a cycle where valid and ready are both 1;
// valid never depends on ready, and data is held while valid waits for ready.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ   = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD     = DEFAULT_BAUD,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [BYTE_W-1:0] rx_data,
    input  logic              rx_ready,
    output logic              rx_overflow,
    output logic              tx_idle,
    output logic              uart_enable,
    output logic [BYTE_W-1:0] uart_data_tx,
    output logic              uart_start_transmit,
    input  logic              uart_tx_ready,
    input  logic [BYTE_W-1:0] uart_data_rx,
    input  logic              uart_receive_done
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    // ---------------- baud divider (free-running) ----------------
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic          baud_tick;

    always_comb begin
        baud_tick  = (baud_cnt_q == CNT_MAX);
        baud_cnt_d = baud_tick ? '0 : baud_cnt_q + CW'(1);
    end

    // ---------------- TX FIFO ----------------
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [BYTE_W-1:0] tx_dout;

    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && tx_ready;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .din   (tx_data),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // ---------------- TX sequencer ----------------
    tx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] data_tx_q, data_tx_d;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= TX_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:  if (!tx_empty) state_d = TX_START;
            // The core samples start only on a tick while it is free.
            TX_START: if (baud_tick && uart_tx_ready) state_d = TX_BUSY;
            TX_BUSY:  if (!uart_tx_ready) state_d = TX_DONE;
            // Ready returns once the stop bit is on the line.
            TX_DONE:  if (uart_tx_ready) state_d = TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pop              = (state_q == TX_IDLE) && !tx_empty;
        uart_start_transmit = (state_q == TX_START);
        tx_idle             = (state_q == TX_IDLE) && tx_empty;
        data_tx_d           = tx_pop ? tx_dout : data_tx_q;
    end

    // ---------------- RX capture ----------------
    logic              rx_done_q, rx_done_d;
    logic              rx_overflow_q, rx_overflow_d;
    logic              rx_edge, rx_push, rx_pop, rx_full, rx_empty;

    always_comb begin
        rx_done_d     = uart_receive_done;
        // Done stays high for about a bit period; capture once per rise.
        rx_edge       = uart_receive_done && !rx_done_q;
        rx_push       = rx_edge && !rx_full;
        rx_valid      = !rx_empty;
        rx_pop        = rx_ready && rx_valid;
        // Full is judged before any same-cycle pop, so the byte is lost.
        rx_overflow_d = rx_overflow_q || (rx_edge && rx_full);
    end

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .din   (uart_data_rx),
        .pop   (rx_pop),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            baud_cnt_q    <= '0;
            data_tx_q     <= '0;
            rx_done_q     <= 1'b0;
            rx_overflow_q <= 1'b0;
        end else begin
            baud_cnt_q    <= baud_cnt_d;
            data_tx_q     <= data_tx_d;
            rx_done_q     <= rx_done_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    assign uart_enable  = baud_tick;
    assign uart_data_tx = data_tx_q;
    assign rx_overflow  = rx_overflow_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl with a behavioural UART core model on the TX side
// and direct drive of the core's receive outputs on the RX side.
module tb_uart_ctrl;

    localparam int CLK_HZ   = 32;
    localparam int BAUD     = 4;
    localparam int DIV      = CLK_HZ / BAUD;
    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_overflow;
    logic       tx_idle;
    logic       uart_enable;
    logic [7:0] uart_data_tx;
    logic       uart_start_transmit;
    logic       uart_tx_ready;
    logic [7:0] uart_data_rx;
    logic       uart_receive_done;

    int errors = 0;
    int checks = 0;

    uart_ctrl #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .tx_valid            (tx_valid),
        .tx_data             (tx_data),
        .tx_ready            (tx_ready),
        .rx_valid            (rx_valid),
        .rx_data             (rx_data),
        .rx_ready            (rx_ready),
        .rx_overflow         (rx_overflow),
        .tx_idle             (tx_idle),
        .uart_enable         (uart_enable),
        .uart_data_tx        (uart_data_tx),
        .uart_start_transmit (uart_start_transmit),
        .uart_tx_ready       (uart_tx_ready),
        .uart_data_rx        (uart_data_rx),
        .uart_receive_done   (uart_receive_done)
    );

    // ---------------- UART core model (transmit side) ----------------
    // Accepts start on a tick while free, then puts one bit per tick on
    // the line: start(0), 8 data bits LSB first, stop(1). Ready returns
    // when the stop bit is issued. Each line bit is logged in line_q; a
    // finished frame is packed as {stop, data[7:0], start} into got_q.
    logic       m_busy = 1'b0;
    int         m_bit = 0;
    logic [7:0] m_shift = 8'h00;
    int         tick_n = 0;
    int         stab_err = 0;
    logic       line_q[$];
    logic [9:0] got_q[$];
    int         start_ticks[$];

    assign uart_tx_ready = !m_busy;

    function automatic logic [9:0] pack_line();
        logic [9:0] f;
        f = 'x;
        if (line_q.size() == 10)
            for (int i = 0; i < 10; i++) f[i] = line_q[i];
        return f;
    endfunction

    always @(posedge clk) begin
        if (uart_enable) tick_n <= tick_n + 1;
        if (!reset) begin
            m_busy <= 1'b0;
            m_bit  <= 0;
            line_q.delete();
        end else begin
            if (m_busy && uart_data_tx !== m_shift) stab_err <= stab_err + 1;
            if (uart_enable) begin
                if (!m_busy) begin
                    if (uart_start_transmit) begin
                        m_busy  <= 1'b1;
                        m_bit   <= 0;
                        m_shift <= uart_data_tx;
                        line_q.delete();
                        line_q.push_back(1'b0);
                        start_ticks.push_back(tick_n);
                    end
                end else if (m_bit < 8) begin
                    line_q.push_back(m_shift[m_bit]);
                    m_bit <= m_bit + 1;
                end else begin
                    m_busy <= 1'b0;
                    line_q.push_back(1'b1);
                    got_q.push_back(pack_line());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int c;
        c = 0;
        while (!tx_ready && c < 2000) begin step(); c++; end
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input int hold);
        uart_data_rx      = b;
        uart_receive_done = 1'b1;
        repeat (hold) step();
        uart_receive_done = 1'b0;
        uart_data_rx      = 8'($urandom);
        repeat (2) step();
    endtask

    task automatic rx_pop();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin step(); c++; end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL frame_timeout: got %0d frames, need %0d", got_q.size(), n);
        end
    endtask

    task automatic wait_tx_idle();
        int c;
        c = 0;
        while (!(tx_idle && !m_busy) && c < 40 * DIV) begin step(); c++; end
        checks++;
        if (!tx_idle) begin
            errors++;
            $display("FAIL tx_idle_timeout: tx_idle=%b want 1", tx_idle);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        uart_data_rx = 8'h00; uart_receive_done = 1'b0;
        repeat (3) step();
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", rx_overflow); end
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL rst_tx_idle: got %b want 1", tx_idle); end
        checks++; if (uart_enable !== 1'b0) begin errors++; $display("FAIL rst_enable: got %b want 0", uart_enable); end
        checks++; if (uart_data_tx !== 8'h00) begin errors++; $display("FAIL rst_data_tx: got %h want 00", uart_data_tx); end
        checks++; if (uart_start_transmit !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", uart_start_transmit); end
    endtask

    // Cycle k after release: tick exactly when k mod DIV == DIV-1.
    task automatic test_baud_tick();
        logic exp_en;
        reset = 1'b1;
        for (int k = 0; k <= 3 * DIV; k++) begin
            exp_en = ((k % DIV) == DIV - 1);
            checks++;
            if (uart_enable !== exp_en) begin
                errors++;
                $display("FAIL baud_tick cycle %0d: got %b want %b", k, uart_enable, exp_en);
            end
            step();
        end
    endtask

    task automatic test_single_send();
        int base_stab;
        wait_tx_idle();
        got_q.delete();
        base_stab = stab_err;
        tx_data = 8'h41; tx_valid = 1'b1;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL send_ready: got %b want 1", tx_ready); end
        step();
        tx_valid = 1'b0;
        checks++; if (uart_start_transmit !== 1'b0) begin errors++; $display("FAIL send_start_early: got %b want 0", uart_start_transmit); end
        checks++; if (tx_idle !== 1'b0) begin errors++; $display("FAIL send_busy_idle: got %b want 0", tx_idle); end
        step();
        checks++; if (uart_start_transmit !== 1'b1) begin errors++; $display("FAIL send_start_latency: got %b want 1", uart_start_transmit); end
        checks++; if (uart_data_tx !== 8'h41) begin errors++; $display("FAIL send_hold: got %h want 41", uart_data_tx); end
        wait_frames(1, 14 * DIV);
        checks++;
        if (got_q.size() < 1 || got_q[0] !== {1'b1, 8'h41, 1'b0}) begin
            errors++;
            $display("FAIL send_line: got %b want %b", (got_q.size() > 0) ? got_q[0] : 10'bx, {1'b1, 8'h41, 1'b0});
        end
        checks++; if (stab_err != base_stab) begin errors++; $display("FAIL send_stable: got %0d changes want 0", stab_err - base_stab); end
        repeat (4) step();
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL send_idle_after: got %b want 1", tx_idle); end
    endtask

    task automatic test_random_tx();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int         n;
        int         base_stab;
        wait_tx_idle();
        got_q.delete();
        base_stab = stab_err;
        n = $urandom_range(4, 7);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push_byte(b);
            repeat ($urandom_range(0, 3 * DIV)) step();
        end
        wait_frames(n, n * 14 * DIV);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {1'b1, exp_q[i], 1'b0}) begin
                errors++;
                $display("FAIL rand_tx[%0d]: got %b want %b", i, got_q[i], {1'b1, exp_q[i], 1'b0});
            end
        end
        checks++; if (stab_err != base_stab) begin errors++; $display("FAIL rand_stable: got %0d changes want 0", stab_err - base_stab); end
    endtask

    // Push every cycle. The first byte is popped on the second push cycle;
    // no further pop happens until its frame ends, many cycles later.
    task automatic test_back_to_back();
        int   occ;
        logic exp_ready;
        wait_tx_idle();
        got_q.delete();
        start_ticks.delete();
        for (int i = 1; i <= TX_DEPTH + 1; i++) begin
            occ = (i <= 2) ? (i - 1) : (i - 2);
            exp_ready = (occ < TX_DEPTH);
            tx_data = 8'(i); tx_valid = 1'b1;
            checks++;
            if (tx_ready !== exp_ready) begin
                errors++;
                $display("FAIL burst_ready push %0d: got %b want %b", i, tx_ready, exp_ready);
            end
            step();
        end
        tx_valid = 1'b0;
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL burst_full: got %b want 0", tx_ready); end
        wait_frames(TX_DEPTH + 1, (TX_DEPTH + 2) * 14 * DIV);
        for (int i = 0; i < TX_DEPTH + 1 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {1'b1, 8'(i + 1), 1'b0}) begin
                errors++;
                $display("FAIL burst_order[%0d]: got %b want %b", i, got_q[i], {1'b1, 8'(i + 1), 1'b0});
            end
        end
        for (int i = 1; i < start_ticks.size(); i++) begin
            checks++;
            if (start_ticks[i] - start_ticks[i-1] < 10 || start_ticks[i] - start_ticks[i-1] > 11) begin
                errors++;
                $display("FAIL burst_gap[%0d]: got %0d ticks want 10..11", i, start_ticks[i] - start_ticks[i-1]);
            end
        end
    endtask

    task automatic test_receive();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int         nb;
        uart_data_rx = 8'h5A; uart_receive_done = 1'b1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pre: got %b want 0", rx_valid); end
        step();
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rx_latency: got %b want 1", rx_valid); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL rx_data: got %h want 5a", rx_data); end
        repeat (DIV - 1) step();
        uart_receive_done = 1'b0;
        step();
        rx_pop();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_single_capture: got %b want 0", rx_valid); end
        for (int it = 0; it < 6; it++) begin
            nb = $urandom_range(1, RX_DEPTH);
            for (int j = 0; j < nb; j++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                rx_frame(b, $urandom_range(1, DIV + 2));
            end
            while (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== b) begin
                    errors++;
                    $display("FAIL rx_rand: got valid=%b data=%h want valid=1 data=%h", rx_valid, rx_data, b);
                end
                rx_pop();
            end
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_drained: got %b want 0", rx_valid); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rx_no_overflow: got %b want 0", rx_overflow); end
    endtask

    task automatic test_overflow();
        rx_frame(8'h11, 3);
        rx_frame(8'h22, 3);
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b want 0", rx_overflow); end
        rx_frame(8'h33, 3);
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", rx_overflow); end
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovf_head0: got %h want 11", rx_data); end
        rx_pop();
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin errors++; $display("FAIL ovf_head1: got valid=%b data=%h want 1 22", rx_valid, rx_data); end
        rx_pop();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b want 0", rx_valid); end
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", rx_overflow); end
    endtask

    // Capture edge and pop together on a full RX FIFO.
    task automatic test_overflow_collide();
        logic [7:0] a, b, c;
        reset = 1'b0; step(); reset = 1'b1;
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL col_reset_ovf: got %b want 0", rx_overflow); end
        a = 8'($urandom); b = 8'($urandom); c = ~b;
        rx_frame(a, 2);
        rx_frame(b, 2);
        uart_data_rx = c; uart_receive_done = 1'b1; rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL col_ovf: got %b want 1", rx_overflow); end
        checks++; if (rx_data !== b) begin errors++; $display("FAIL col_head: got %h want %h", rx_data, b); end
        repeat (2) step();
        uart_receive_done = 1'b0;
        step();
        rx_pop();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL col_dropped: got %b want 0", rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int         c;
        logic [7:0] b;
        wait_tx_idle();
        rx_frame(8'($urandom), 2);
        push_byte(8'hFF);
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        c = 0;
        while (!(m_busy && m_bit == 5) && c < 20 * DIV) begin step(); c++; end
        checks++; if (!(m_busy && m_bit == 5)) begin errors++; $display("FAIL mid_reach_bit4: got busy=%b bit=%0d want 1 5", m_busy, m_bit); end
        reset = 1'b0;
        step();
        checks++; if (uart_start_transmit !== 1'b0) begin errors++; $display("FAIL mid_start: got %b want 0", uart_start_transmit); end
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL mid_tx_idle: got %b want 1", tx_idle); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_tx_ready: got %b want 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rx_valid: got %b want 0", rx_valid); end
        reset = 1'b1;
        got_q.delete();
        b = 8'($urandom);
        push_byte(b);
        wait_frames(1, 14 * DIV);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {1'b1, b, 1'b0}) begin
            errors++;
            $display("FAIL mid_resend: got %0d frames first=%b want 1 frame %b", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'bx, {1'b1, b, 1'b0});
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_baud_tick();
        test_single_send();
        test_random_tx();
        test_back_to_back();
        test_receive();
        test_overflow();
        test_overflow_collide();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
